mem_responder: RTL and testbench

- Memory-side responder for the core's data/instruction memory interface; it is the target end of the core's load/store/fetch requests.
- Accepts one request at a time over a valid/ready request channel.
- Performs a word read or byte-masked word write on an internal RAM after a programmable number of wait states.
- Returns the result over a valid/ready response channel, with an error flag for bad addresses.

---
 rtl/mem_responder.sv | 154 +++++++++++++++
 tb/tb_mem_responder.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Single-outstanding memory target: accepts one request, waits WAIT_CYCLES,
// performs a word read or byte-masked write on internal RAM, then returns the response.
module mem_responder #(
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_be_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int unsigned Depth = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        ready_q, ready_d;
    logic        valid_q, valid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [Depth];

    logic                  access;
    logic                  use_in;
    logic                  acc_we;
    logic [31:0]           acc_addr;
    logic [31:0]           acc_wdata;
    logic [3:0]            acc_be;
    logic                  acc_err;
    logic [DEPTH_LOG2-1:0] acc_idx;

    // With zero wait states the access happens on the accept edge, so it uses the live inputs.
    always_comb begin
        acc_we    = use_in ? req_we_i    : we_q;
        acc_addr  = use_in ? req_addr_i  : addr_q;
        acc_wdata = use_in ? req_wdata_i : wdata_q;
        acc_be    = use_in ? req_be_i    : be_q;
        acc_err   = (acc_addr[1:0] != 2'b00) || ((acc_addr >> (DEPTH_LOG2 + 2)) != '0);
        acc_idx   = acc_addr[DEPTH_LOG2+1:2];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        ready_d = ready_q;
        valid_d = valid_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        access  = 1'b0;
        use_in  = 1'b0;
        unique case (state_q)
            StIdle: begin
                ready_d = 1'b1;
                if (req_valid_i && ready_q) begin
                    ready_d = 1'b0;
                    we_d    = req_we_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    be_d    = req_be_i;
                    if (WAIT_CYCLES == 0) begin
                        access  = 1'b1;
                        use_in  = 1'b1;
                        state_d = StResp;
                    end else begin
                        cnt_d   = 4'(WAIT_CYCLES);
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    access  = 1'b1;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    valid_d = 1'b0;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    ready_d = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (access) begin
            valid_d = 1'b1;
            err_d   = acc_err;
            rdata_d = (!acc_err && !acc_we) ? mem_q[acc_idx] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // RAM is not reset, but a reset on the access edge must still suppress the write.
    always_ff @(posedge clk) begin
        if (!reset && access && acc_we && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_be[b]) mem_q[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
            end
        end
    end

    assign req_ready_o = ready_q;
    assign rsp_valid_o = valid_q;
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a two-wait-state instance under directed and random
// traffic, plus a zero-wait-state instance driven back-to-back.
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [3:0]  req_be;
    logic        req_valid0, req_ready0, req_we0, rsp_valid0, rsp_err0;
    logic        rsp_ready0 = 1'b1;
    logic [31:0] req_addr0, req_wdata0, rsp_rdata0;
    logic [3:0]  req_be0;

    mem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err)
    );

    mem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid0), .req_ready_o(req_ready0), .req_we_i(req_we0),
        .req_addr_i(req_addr0), .req_wdata_i(req_wdata0), .req_be_i(req_be0),
        .rsp_valid_o(rsp_valid0), .rsp_ready_i(rsp_ready0),
        .rsp_rdata_o(rsp_rdata0), .rsp_err_o(rsp_err0)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        bit          known;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    exp_t        sb0[$];
    logic [31:0] mdl[int];  // key = instance*65536 + word index
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    bit          rand_bp = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Reference behaviour: 4 KiB word-addressed memory, misaligned or >= 4 KiB faults.
    function automatic exp_t predict(int sel, logic we, logic [31:0] addr, logic [31:0] wdata,
                                     logic [3:0] be, int acc);
        exp_t        e;
        int          key;
        logic [31:0] w;
        e.acc   = acc;
        e.err   = (addr % 4 != 0) || (addr >= 32'd4096);
        e.rdata = '0;
        e.known = 1'b1;
        if (!e.err) begin
            key = sel * 65536 + int'(addr / 4);
            w   = mdl.exists(key) ? mdl[key] : 32'h0;
            if (we) begin
                for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wdata[8*b +: 8];
                mdl[key] = w;
            end else begin
                e.known = mdl.exists(key);
                e.rdata = w;
            end
        end
        return e;
    endfunction

    // Monitor for the two-wait-state instance.
    initial begin
        bit          new_rsp = 1;
        logic [31:0] prev_rdata = '0;
        logic        prev_err = 1'b0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (reset) begin
                new_rsp = 1;
            end else if (rsp_valid) begin
                if (new_rsp) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_rsp", 32'(rsp_valid), 32'(0));
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_err", 32'(rsp_err), 32'(e.err));
                        if (e.known) chk("rsp_rdata", rsp_rdata, e.rdata);
                        chk("rsp_latency", 32'(cyc - e.acc), 32'(3));
                    end
                end else begin
                    chk("hold_rdata", rsp_rdata, prev_rdata);
                    chk("hold_err", 32'(rsp_err), 32'(prev_err));
                end
                chk("ready_low_in_resp", 32'(req_ready), 32'(0));
                prev_rdata = rsp_rdata;
                prev_err   = rsp_err;
                new_rsp    = rsp_ready;
            end else begin
                chk("idle_rdata_zero", rsp_rdata, 32'(0));
                new_rsp = 1;
            end
        end
    end

    // Monitor for the zero-wait-state instance: also records acceptances.
    initial begin
        int   last_acc = -1;
        logic prev_valid = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (rsp_valid0) begin
                    chk("rsp0_single_cycle", 32'(prev_valid), 32'(0));
                    if (sb0.size() == 0) begin
                        chk("unexpected_rsp0", 32'(rsp_valid0), 32'(0));
                    end else begin
                        e = sb0.pop_front();
                        chk("rsp0_err", 32'(rsp_err0), 32'(e.err));
                        if (e.known) chk("rsp0_rdata", rsp_rdata0, e.rdata);
                        chk("rsp0_latency", 32'(cyc - e.acc), 32'(1));
                    end
                end
                if (req_valid0 && req_ready0) begin
                    sb0.push_back(predict(1, req_we0, req_addr0, req_wdata0, req_be0, cyc));
                    if (last_acc >= 0) chk("acc0_spacing", 32'(cyc - last_acc), 32'(2));
                    last_acc = cyc;
                end
            end
            prev_valid = rsp_valid0;
        end
    end

    // Random response back-pressure when enabled.
    initial forever begin
        @(posedge clk);
        #1;
        if (rand_bp) rsp_ready = 1'($urandom_range(0, 1));
    end

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input bit track);
        int n = 0;
        @(posedge clk);
        #1;
        while (!req_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 32'(req_ready), 32'(1));
            return;
        end
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        @(negedge clk);
        if (track) sb.push_back(predict(0, we, addr, wdata, be, cyc));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = 4'($urandom);
    endtask

    task automatic wait_valid();
        int n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) chk("rsp_valid_timeout", 32'(rsp_valid), 32'(1));
    endtask

    task automatic wait_drain();
        int n = 0;
        @(negedge clk);
        while ((sb.size() != 0 || rsp_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(sb.size()), 32'(0));
    endtask

    initial begin
        #300000;
        failures++;
        $display("FAIL watchdog actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        reset = 1'b1;
        rsp_ready = 1'b1;
        {req_valid, req_we, req_addr, req_wdata, req_be} = '0;
        {req_valid0, req_we0, req_addr0, req_wdata0, req_be0} = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'(0));
        chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rst_rsp_rdata", rsp_rdata, 32'(0));
        chk("rst_rsp_err", 32'(rsp_err), 32'(0));
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_reset", 32'(req_ready), 32'(1));
        chk("ready0_after_reset", 32'(req_ready0), 32'(1));

        // Zero-wait instance: continuous valid, responses always accepted.
        for (int i = 0; i < 10; i++) begin
            int n = 0;
            req_valid0 = 1'b1;
            req_we0    = (i < 4);
            req_addr0  = (i == 9) ? 32'h2 : 32'(4 * (i % 4));
            req_wdata0 = $urandom;
            req_be0    = 4'hF;
            @(negedge clk);
            while (!req_ready0 && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (!req_ready0) chk("accept0_timeout", 32'(req_ready0), 32'(1));
            @(posedge clk);
            #1;
        end
        req_valid0 = 1'b0;
        repeat (4) @(posedge clk);
        chk("sb0_drained", 32'(sb0.size()), 32'(0));

        // Directed traffic.
        issue(1'b1, 32'h0, 32'h0BADF00D, 4'hF, 1);
        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1);
        issue(1'b0, 32'h10, 32'h0, 4'h0, 1);
        issue(1'b1, 32'h10, 32'h11223344, 4'b0101, 1);
        issue(1'b0, 32'h10, 32'h0, 4'hF, 1);
        issue(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 1);
        issue(1'b0, 32'h10, 32'h0, 4'h0, 1);
        issue(1'b0, 32'h12, 32'h0, 4'hF, 1);
        issue(1'b1, 32'h1000, 32'h12345678, 4'hF, 1);
        issue(1'b0, 32'h0, 32'h0, 4'h0, 1);
        for (int w = 1; w < 16; w++) if (w != 4) issue(1'b1, 32'(4 * w), $urandom, 4'hF, 1);

        // Back-pressure: hold response, pulse a request that must be ignored.
        wait_drain();
        rsp_ready = 1'b0;
        issue(1'b0, 32'h10, 32'h0, 4'h0, 1);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) begin
                req_valid = 1'b1;
                req_we    = 1'b1;
                req_addr  = 32'h0;
                req_wdata = 32'hFEEDFACE;
                req_be    = 4'hF;
            end
            if (i == 3) req_valid = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_after_release", 32'(req_ready), 32'(1));
        chk("valid_low_after_release", 32'(rsp_valid), 32'(0));
        issue(1'b0, 32'h0, 32'h0, 4'h0, 1);

        // Reset while a write to 0x20 waits: it must never land.
        wait_drain();
        issue(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk("wait_reset_no_rsp", 32'(rsp_valid), 32'(0));
        end
        issue(1'b0, 32'h20, 32'h0, 4'h0, 1);

        // Reset while the write response is held: the write stays.
        wait_drain();
        rsp_ready = 1'b0;
        issue(1'b1, 32'h24, 32'h5A5AA5A5, 4'hF, 1);
        wait_valid();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        rsp_ready = 1'b1;
        chk("resp_reset_valid", 32'(rsp_valid), 32'(0));
        issue(1'b0, 32'h24, 32'h0, 4'h0, 1);

        // Random traffic with random back-pressure.
        wait_drain();
        rand_bp = 1;
        for (int i = 0; i < 80; i++) begin
            int op = $urandom_range(0, 9);
            a = 32'(4 * $urandom_range(0, 15));
            if (op == 6) a = a | 32'($urandom_range(1, 3));
            if (op == 7) a = ($urandom & ~32'h3) | 32'h1000;
            if (op == 8) a = a | 32'h8000_0000;
            issue((op < 3) ? 1'b1 : 1'b0, a, $urandom, 4'($urandom), 1);
        end
        rand_bp = 0;
        @(posedge clk);
        #2;
        rsp_ready = 1'b1;
        wait_drain();
        repeat (3) @(posedge clk);
        chk("final_sb_empty", 32'(sb.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
